// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// one bit per clock LSB first, start/ready handshake in, single-cycle done out.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic bit_s;
  logic c_next;

  // The single full-adder cell, fed by the LSBs of the operand shift registers.
  assign bit_s  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        ps_d  = {bit_s, ps_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        if (cnt_q == CNT_LAST) begin
          // Counter holds at its last value; the next start reloads it.
          sum_d   = {bit_s, ps_q[WIDTH-1:1]};
          cout_d  = c_next;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: doc/serial_full_adder.md
# serial_full_adder

Bit-serial N-bit adder built around a single full-adder cell plus a registered carry. It performs the inverse arithmetic of the team's gate-level full subtractor.
- Accepts two WIDTH-bit operands and a carry-in through a start/ready handshake.
- Processes one bit per clock, LSB first.
- Presents sum and carry-out with a one-cycle done pulse.

It is intended as the area-minimal addition path alongside the existing combinational subtractor cells, and as a sequential DUT for the same style of exhaustive directed benches.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  augend, captured on accepted start
- b  input  WIDTH  addend, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- ready  output  1  high in IDLE and DONE (start will be accepted)
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  result, held until the next accepted start completes
- cout  output  1  carry-out of MSB, held like sum

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: bit-serial addition in progress.
  - DONE: result just produced.
- IDLE/DONE + start=1:
  - Load the operand shift registers with a and b.
  - Load the carry register with cin.
  - Clear the bit counter to 0.
  - Go to SHIFT.
- IDLE + start=0 → IDLE. DONE + start=0 → IDLE.
- SHIFT, each cycle:
  - Compute s = a_r[0]^b_r[0]^c_r and c_next = a_r[0]&b_r[0] | c_r&(a_r[0]^b_r[0]).
  - Shift s into the MSB of the partial-sum register, which shifts right.
  - Shift a_r and b_r right by one.
  - Set c_r ← c_next and increment the counter.
- SHIFT when counter = WIDTH-1:
  - Copy the completed partial sum into sum and c_next into cout.
  - Assert done for the next cycle and go to DONE.
- Result is exactly (a + b + cin) mod 2^WIDTH, and cout = bit WIDTH of that sum.
- start while busy=1 is ignored: operands are not re-captured and there is no queueing.
- sum/cout change only on the transition SHIFT→DONE. Internal shift registers are not visible on the outputs.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH-1 is possible in legal operation.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0.
  - Counter, carry and shift registers cleared.
- Reset mid-SHIFT aborts the operation immediately. No done is produced.
- Release of reset is synchronous to the next rising edge.
- start accepted at edge k:
  - busy=1 and ready=0 from edge k through edge k+WIDTH.
  - done=1, busy=0 and ready=1 for the single cycle between edges k+WIDTH and k+WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to the done pulse.
- Throughput:
  - start asserted during the done cycle is accepted at edge k+WIDTH+1.
  - Back-to-back operations therefore complete every WIDTH+1 cycles.
  - done is not re-asserted until the new operation finishes, and sum/cout hold the old result meanwhile.
- done never remains high for two consecutive cycles.
- All outputs are registered except ready and busy, which decode the state register directly.

## Test plan
- Reset then idle:
  - Assert rst_n=0 mid-cycle → outputs go to reset values immediately.
  - Hold start=0 for 20 cycles after release → ready=1, done never pulses.
- Basic add, WIDTH=8:
  - a=3, b=5, cin=0 → done exactly 8 cycles after the accepting edge, sum=8, cout=0.
  - a=0, b=0, cin=1 → sum=1, cout=0.
- Carry ripple:
  - a=255, b=1, cin=0 → sum=0, cout=1.
  - a=255, b=255, cin=1 → sum=255, cout=1.
  - Exhaustive sweep at WIDTH=4 over all a, b, cin (512 ops) against a+b+cin.
- Busy protection:
  - Accept a=10, b=20.
  - Pulse start with a=1, b=1 at cycle 3 of SHIFT → ignored; result is sum=30, done pulses once.
- Reset mid-operation:
  - Drop rst_n at cycle 4 of SHIFT → state IDLE immediately, no done, sum=0.
  - A new op a=7, b=9 → sum=16.
- Back-to-back:
  - Hold start high continuously with a=100, b=27 then a=200, b=100 → done pulses 9 cycles apart.
  - Results are sum=127/cout=0, then sum=44/cout=1.
  - sum holds 127 until the second done.
